// File: rtl/memport_req.sv
// Request front end for a memory block: registers read/write commands toward the
// memory, tracks outstanding read tags in order and turns read returns into responses.
module memport_req #(
  parameter int DEPTH = 64,
  parameter int TAGW  = 6
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [38:0]              req_addr,
  input  logic [39:0]              req_phy,
  input  logic [532:0]             req_wdata,
  input  logic [TAGW-1:0]          req_tag,

  output logic [38:0]              mem_rdaddr0,
  output logic [39:0]              mem_rdphydata0,
  output logic                     mem_rden,
  output logic [38:0]              mem_wraddr0,
  output logic [532:0]             mem_wrdata,
  output logic                     mem_wren,
  input  logic                     mem_stall,

  input  logic                     mem_rden_ret,
  input  logic [532:0]             mem_rddata,

  output logic                     rsp_valid,
  output logic [TAGW-1:0]          rsp_tag,
  output logic [532:0]             rsp_data,

  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     err_unexp
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(DEPTH);

  // Handshake and return classification
  logic accept;
  logic rd_accept;
  logic wr_accept;
  logic ret_pop;
  logic ret_unexp;

  // Memory-side command registers
  logic         rden_q, rden_d;
  logic         wren_q, wren_d;
  logic [38:0]  rdaddr_q, rdaddr_d;
  logic [39:0]  rdphy_q, rdphy_d;
  logic [38:0]  wraddr_q, wraddr_d;
  logic [532:0] wrdata_q, wrdata_d;

  // Tag FIFO
  logic [TAGW-1:0] tag_mem [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [TAGW-1:0] head_tag;

  // Response registers
  logic            rsp_valid_q, rsp_valid_d;
  logic [TAGW-1:0] rsp_tag_q, rsp_tag_d;
  logic [532:0]    rsp_data_q, rsp_data_d;
  logic            err_q, err_d;

  // Ready is also low during reset so nothing is accepted into cleared state.
  always_comb begin
    req_ready = !rst && !mem_stall && (count_q < FULL_COUNT);
    accept    = req_valid && req_ready;
    rd_accept = accept && !req_we;
    wr_accept = accept && req_we;
    ret_pop   = mem_rden_ret && (count_q != '0);
    ret_unexp = mem_rden_ret && (count_q == '0);
  end

  always_comb begin
    rden_d   = rden_q;
    wren_d   = wren_q;
    rdaddr_d = rdaddr_q;
    rdphy_d  = rdphy_q;
    wraddr_d = wraddr_q;
    wrdata_d = wrdata_q;
    // A stalled memory is not sampling, so every command output must hold.
    if (!mem_stall) begin
      rden_d = rd_accept;
      wren_d = wr_accept;
      if (rd_accept) begin
        rdaddr_d = req_addr;
        rdphy_d  = req_phy;
      end
      if (wr_accept) begin
        wraddr_d = req_addr;
        wrdata_d = req_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rden_q   <= 1'b0;
      wren_q   <= 1'b0;
      rdaddr_q <= '0;
      rdphy_q  <= '0;
      wraddr_q <= '0;
      wrdata_q <= '0;
    end else begin
      rden_q   <= rden_d;
      wren_q   <= wren_d;
      rdaddr_q <= rdaddr_d;
      rdphy_q  <= rdphy_d;
      wraddr_q <= wraddr_d;
      wrdata_q <= wrdata_d;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTRW'(rd_accept);
    rd_ptr_d = rd_ptr_q + PTRW'(ret_pop);
    count_d  = count_q;
    case ({rd_accept, ret_pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_accept) begin
      tag_mem[wr_ptr_q] <= req_tag;
    end
  end

  assign head_tag = tag_mem[rd_ptr_q];

  // A return with nothing outstanding still produces a response, tagged zero.
  always_comb begin
    rsp_valid_d = mem_rden_ret;
    rsp_tag_d   = rsp_tag_q;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q || ret_unexp;
    if (mem_rden_ret) begin
      rsp_data_d = mem_rddata;
      rsp_tag_d  = ret_pop ? head_tag : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  assign mem_rden       = rden_q;
  assign mem_wren       = wren_q;
  assign mem_rdaddr0    = rdaddr_q;
  assign mem_rdphydata0 = rdphy_q;
  assign mem_wraddr0    = wraddr_q;
  assign mem_wrdata     = wrdata_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_tag        = rsp_tag_q;
  assign rsp_data       = rsp_data_q;
  assign outstanding    = count_q;
  assign err_unexp      = err_q;

  a_one_strobe: assert property (@(posedge clk) disable iff (rst) !(rden_q && wren_q));
  a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= FULL_COUNT);

endmodule

// File: tb/tb_memport_req.sv
// Self-checking bench for memport_req: a table of directed cycles, hand-written
// corner sequences and randomized traffic, all compared against a queue-based model.
module tb_memport_req;

  localparam int DEPTH = 64;
  localparam int TAGW  = 6;

  typedef struct {
    bit              rst;
    bit              valid;
    bit              we;
    bit              stall;
    bit              ret;
    logic [38:0]     addr;
    logic [39:0]     phy;
    logic [532:0]    wdata;
    logic [TAGW-1:0] tag;
    logic [532:0]    rddata;
  } stim_t;

  typedef struct {
    stim_t           s;
    bit              exp_ready;
    bit              exp_rden;
    bit              exp_wren;
    bit              exp_rspv;
    int              exp_out;
    bit              exp_err;
    logic [TAGW-1:0] exp_tag;
  } vec_t;

  logic                  clk;
  logic                  rst;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [38:0]           req_addr;
  logic [39:0]           req_phy;
  logic [532:0]          req_wdata;
  logic [TAGW-1:0]       req_tag;
  logic [38:0]           mem_rdaddr0;
  logic [39:0]           mem_rdphydata0;
  logic                  mem_rden;
  logic [38:0]           mem_wraddr0;
  logic [532:0]          mem_wrdata;
  logic                  mem_wren;
  logic                  mem_stall;
  logic                  mem_rden_ret;
  logic [532:0]          mem_rddata;
  logic                  rsp_valid;
  logic [TAGW-1:0]       rsp_tag;
  logic [532:0]          rsp_data;
  logic [$clog2(DEPTH):0] outstanding;
  logic                  err_unexp;

  memport_req #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_phy        (req_phy),
    .req_wdata      (req_wdata),
    .req_tag        (req_tag),
    .mem_rdaddr0    (mem_rdaddr0),
    .mem_rdphydata0 (mem_rdphydata0),
    .mem_rden       (mem_rden),
    .mem_wraddr0    (mem_wraddr0),
    .mem_wrdata     (mem_wrdata),
    .mem_wren       (mem_wren),
    .mem_stall      (mem_stall),
    .mem_rden_ret   (mem_rden_ret),
    .mem_rddata     (mem_rddata),
    .rsp_valid      (rsp_valid),
    .rsp_tag        (rsp_tag),
    .rsp_data       (rsp_data),
    .outstanding    (outstanding),
    .err_unexp      (err_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: tags in flight are just an ordered queue.
  logic [TAGW-1:0] tag_q[$];
  bit              m_ready;
  bit              m_rden, m_wren, m_rsp_valid, m_err;
  logic [38:0]     m_rdaddr, m_wraddr;
  logic [39:0]     m_phy;
  logic [532:0]    m_wdata, m_rsp_data;
  logic [TAGW-1:0] m_rsp_tag;

  function automatic void check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endfunction

  function automatic void check_vec(input string name, input logic [532:0] act, input logic [532:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [532:0] make_line(input int unsigned seed);
    logic [532:0] l;
    l = '0;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = seed * 32'(k + 1) + 32'h9E37_79B9;
    l[532:512] = seed[20:0];
    return l;
  endfunction

  function automatic logic [532:0] rand_line();
    logic [532:0] l;
    l = '0;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = $urandom;
    l[532:512] = 21'($urandom);
    return l;
  endfunction

  function automatic stim_t mk(input bit r, input bit v, input bit w, input logic [38:0] a,
                               input logic [TAGW-1:0] t, input bit st, input bit rt);
    stim_t s;
    s.rst    = r;
    s.valid  = v;
    s.we     = w;
    s.stall  = st;
    s.ret    = rt;
    s.addr   = a;
    s.phy    = {1'b1, a};
    s.wdata  = make_line(a[31:0]);
    s.tag    = t;
    s.rddata = make_line(a[31:0] ^ 32'h5A5A_0F0F);
    return s;
  endfunction

  function automatic vec_t row(input stim_t s, input bit rdy, input bit rd, input bit wr,
                               input bit rv, input int o, input bit e, input logic [TAGW-1:0] t);
    vec_t v;
    v.s         = s;
    v.exp_ready = rdy;
    v.exp_rden  = rd;
    v.exp_wren  = wr;
    v.exp_rspv  = rv;
    v.exp_out   = o;
    v.exp_err   = e;
    v.exp_tag   = t;
    return v;
  endfunction

  task automatic checkOutput();
    check_bit("mem_rden", mem_rden, m_rden);
    check_bit("mem_wren", mem_wren, m_wren);
    if (m_rden) begin
      check_vec("mem_rdaddr0", 533'(mem_rdaddr0), 533'(m_rdaddr));
      check_vec("mem_rdphydata0", 533'(mem_rdphydata0), 533'(m_phy));
    end
    if (m_wren) begin
      check_vec("mem_wraddr0", 533'(mem_wraddr0), 533'(m_wraddr));
      check_vec("mem_wrdata", mem_wrdata, m_wdata);
    end
    check_bit("rsp_valid", rsp_valid, m_rsp_valid);
    if (m_rsp_valid) begin
      check_vec("rsp_tag", 533'(rsp_tag), 533'(m_rsp_tag));
      check_vec("rsp_data", rsp_data, m_rsp_data);
    end
    check_vec("outstanding", 533'(outstanding), 533'(tag_q.size()));
    check_bit("err_unexp", err_unexp, m_err);
  endtask

  // Drives one cycle, checks ready before the edge and all outputs after it.
  task automatic applyStimulus(input stim_t s, output bit ready_seen);
    bit acc;
    rst          = s.rst;
    req_valid    = s.valid;
    req_we       = s.we;
    req_addr     = s.addr;
    req_phy      = s.phy;
    req_wdata    = s.wdata;
    req_tag      = s.tag;
    mem_stall    = s.stall;
    mem_rden_ret = s.ret;
    mem_rddata   = s.rddata;
    #1;
    ready_seen = req_ready;
    m_ready = !s.rst && !s.stall && (tag_q.size() < DEPTH);
    check_bit("req_ready", req_ready, m_ready);
    if (s.rst) begin
      tag_q.delete();
      m_rden = 0; m_wren = 0; m_rsp_valid = 0; m_err = 0;
      m_rdaddr = '0; m_wraddr = '0; m_phy = '0; m_wdata = '0;
    end else begin
      acc = s.valid && m_ready;
      m_rsp_valid = s.ret;
      if (s.ret) begin
        m_rsp_data = s.rddata;
        if (tag_q.size() > 0) m_rsp_tag = tag_q.pop_front();
        else begin
          m_rsp_tag = '0;
          m_err     = 1;
        end
      end
      if (acc && !s.we) tag_q.push_back(s.tag);
      if (!s.stall) begin
        m_rden = acc && !s.we;
        m_wren = acc && s.we;
        if (acc && !s.we) begin
          m_rdaddr = s.addr;
          m_phy    = s.phy;
        end
        if (acc && s.we) begin
          m_wraddr = s.addr;
          m_wdata  = s.wdata;
        end
      end
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    bit   rdy;
    stim_t s;

    rst = 1; req_valid = 0; req_we = 0; req_addr = '0; req_phy = '0; req_wdata = '0;
    req_tag = '0; mem_stall = 0; mem_rden_ret = 0; mem_rddata = '0;
    m_rden = 0; m_wren = 0; m_rsp_valid = 0; m_err = 0; m_ready = 0;
    m_rdaddr = '0; m_wraddr = '0; m_phy = '0; m_wdata = '0; m_rsp_data = '0; m_rsp_tag = '0;

    //                 rst v  we addr            tag st rt     rdy rd wr rv out err tag
    vecs.push_back(row(mk(1, 0, 0, 39'h0,        0, 0, 0),    0,  0, 0, 0, 0,  0,  0));
    vecs.push_back(row(mk(0, 1, 0, 39'h12345670, 5, 0, 0),    1,  1, 0, 0, 1,  0,  0));
    vecs.push_back(row(mk(0, 0, 0, 39'h0,        0, 0, 0),    1,  0, 0, 0, 1,  0,  0));
    vecs.push_back(row(mk(0, 0, 0, 39'h3,        0, 0, 1),    1,  0, 0, 1, 0,  0,  5));
    vecs.push_back(row(mk(0, 0, 0, 39'h0,        0, 0, 0),    1,  0, 0, 0, 0,  0,  0));
    vecs.push_back(row(mk(0, 1, 0, 39'h100,      9, 0, 0),    1,  1, 0, 0, 1,  0,  0));
    vecs.push_back(row(mk(0, 1, 0, 39'h200,     12, 0, 1),    1,  1, 0, 1, 1,  0,  9));
    vecs.push_back(row(mk(0, 0, 0, 39'h7,        0, 0, 1),    1,  0, 0, 1, 0,  0, 12));
    vecs.push_back(row(mk(0, 1, 1, 39'hABC,      0, 0, 0),    1,  0, 1, 0, 0,  0,  0));
    vecs.push_back(row(mk(0, 1, 1, 39'hDEF,      0, 1, 0),    0,  0, 1, 0, 0,  0,  0));
    vecs.push_back(row(mk(0, 0, 0, 39'h0,        0, 1, 0),    0,  0, 1, 0, 0,  0,  0));
    vecs.push_back(row(mk(0, 0, 0, 39'h0,        0, 0, 0),    1,  0, 0, 0, 0,  0,  0));
    vecs.push_back(row(mk(0, 0, 0, 39'h9,        0, 0, 1),    1,  0, 0, 1, 0,  1,  0));
    vecs.push_back(row(mk(0, 0, 0, 39'h0,        0, 0, 0),    1,  0, 0, 0, 0,  1,  0));
    vecs.push_back(row(mk(1, 0, 0, 39'h0,        0, 0, 0),    0,  0, 0, 0, 0,  0,  0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].s, rdy);
      check_bit($sformatf("vec%0d_ready", i), rdy, vecs[i].exp_ready);
      check_bit($sformatf("vec%0d_rden", i), mem_rden, vecs[i].exp_rden);
      check_bit($sformatf("vec%0d_wren", i), mem_wren, vecs[i].exp_wren);
      check_bit($sformatf("vec%0d_rspv", i), rsp_valid, vecs[i].exp_rspv);
      check_vec($sformatf("vec%0d_out", i), 533'(outstanding), 533'(vecs[i].exp_out));
      check_bit($sformatf("vec%0d_err", i), err_unexp, vecs[i].exp_err);
      if (vecs[i].exp_rspv) check_vec($sformatf("vec%0d_tag", i), 533'(rsp_tag), 533'(vecs[i].exp_tag));
      if (i == 0) begin
        check_vec("reset_rdaddr", 533'(mem_rdaddr0), '0);
        check_vec("reset_wraddr", 533'(mem_wraddr0), '0);
        check_vec("reset_wrdata", mem_wrdata, '0);
      end
    end

    // Write issued, then memory stalls for three cycles.
    applyStimulus(mk(0, 1, 1, 39'h55AA, 0, 0, 0), rdy);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(mk(0, 1, 1, 39'(k + 16), 0, 1, 0), rdy);
      check_bit("stall_wren_held", mem_wren, 1'b1);
      check_vec("stall_wraddr_held", 533'(mem_wraddr0), 533'(39'h55AA));
    end
    applyStimulus(mk(0, 0, 0, 39'h0, 0, 0, 0), rdy);
    check_bit("stall_wren_dropped", mem_wren, 1'b0);
    check_vec("stall_outstanding", 533'(outstanding), '0);

    // Fill the tag FIFO completely.
    for (int t = 0; t < DEPTH; t++) applyStimulus(mk(0, 1, 0, 39'(t * 16 + 4096), TAGW'(t), 0, 0), rdy);
    check_vec("full_outstanding", 533'(outstanding), 533'(DEPTH));
    applyStimulus(mk(0, 1, 0, 39'h777, 6'd63, 0, 0), rdy);
    check_bit("full_ready_low", rdy, 1'b0);
    applyStimulus(mk(0, 1, 0, 39'h778, 6'd7, 0, 1), rdy);
    check_bit("full_pop_ready_low", rdy, 1'b0);
    check_bit("full_pop_rsp_valid", rsp_valid, 1'b1);
    check_vec("full_pop_tag", 533'(rsp_tag), '0);
    applyStimulus(mk(0, 0, 0, 39'h0, 0, 0, 0), rdy);
    check_bit("ready_reasserts", rdy, 1'b1);

    // Drain to 10, push and pop together, then refill and drain across the wrap.
    for (int k = 0; k < 53; k++) applyStimulus(mk(0, 0, 0, 39'(k + 300), 0, 0, 1), rdy);
    check_vec("drain_outstanding", 533'(outstanding), 533'(10));
    applyStimulus(mk(0, 1, 0, 39'h999, 6'd40, 0, 1), rdy);
    check_vec("pushpop_outstanding", 533'(outstanding), 533'(10));
    check_vec("pushpop_tag", 533'(rsp_tag), 533'(54));
    for (int k = 0; k < 30; k++) applyStimulus(mk(0, 1, 0, 39'(k + 500), TAGW'(k + 20), 0, k[0]), rdy);
    for (int k = 0; k < 200 && tag_q.size() > 0; k++) applyStimulus(mk(0, 0, 0, 39'(k + 700), 0, 0, 1), rdy);
    check_vec("wrap_drained", 533'(outstanding), '0);
    check_bit("wrap_no_err", err_unexp, 1'b0);

    // Reset with five reads in flight.
    for (int k = 0; k < 5; k++) applyStimulus(mk(0, 1, 0, 39'(k + 900), TAGW'(k + 1), 0, 0), rdy);
    applyStimulus(mk(1, 0, 0, 39'h0, 0, 0, 0), rdy);
    check_vec("rst_mid_outstanding", 533'(outstanding), '0);
    check_bit("rst_mid_rden", mem_rden, 1'b0);
    check_bit("rst_mid_wren", mem_wren, 1'b0);
    applyStimulus(mk(0, 0, 0, 39'h0, 0, 0, 0), rdy);
    applyStimulus(mk(0, 0, 0, 39'h44, 0, 0, 1), rdy);
    check_bit("rst_mid_late_err", err_unexp, 1'b1);
    check_vec("rst_mid_late_tag", 533'(rsp_tag), '0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      s.rst    = ($urandom_range(399, 0) == 0);
      s.valid  = ($urandom_range(9, 0) < 7);
      s.we     = ($urandom_range(9, 0) < 4);
      s.stall  = ($urandom_range(3, 0) == 0);
      s.ret    = (tag_q.size() > 0) ? ($urandom_range(99, 0) < ((i < 1500) ? 20 : 55))
                                    : ($urandom_range(99, 0) < 2);
      s.addr   = 39'({$urandom, $urandom});
      s.phy    = 40'({$urandom, $urandom});
      s.wdata  = rand_line();
      s.tag    = TAGW'($urandom);
      s.rddata = rand_line();
      applyStimulus(s, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
